tpu_job_scheduler: RTL and testbench

Shares one `tpu_top` instance between NUM_REQ requesters, such as host DMA queues or layer sequencers. It picks the next job round-robin, issues the single-cycle `tpu_start`, and supervises the run with a watchdog. It then reports completion, with tag and status, back to the requester that owns the job. It sits between the requesters and the datapath's `tpu_start`/`tpu_done` pins, and drives `tpu_abort`, which the integrator ORs into the datapath's reset.

---
 rtl/tpu_sched_pkg.sv | 16 +
 rtl/tpu_rr_arbiter.sv | 32 +++
 rtl/tpu_job_scheduler.sv | 140 ++++++++++++++
 tb/tb_tpu_job_scheduler.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/tpu_sched_pkg.sv
// Shared types and constants for the TPU job scheduler.
package tpu_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_RUN      = 3'd2,
    ST_ABORT    = 3'd3,
    ST_COMPLETE = 3'd4,
    ST_DRAIN    = 3'd5
  } state_e;

  localparam logic STATUS_OK      = 1'b0;
  localparam logic STATUS_TIMEOUT = 1'b1;

endpackage

// File: rtl/tpu_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above rr_ptr, wrapping.
module tpu_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  int unsigned j;
  logic        found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    j         = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      j = 32'(rr_ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && req[IDX_W'(j)]) begin
        found                 = 1'b1;
        grant[IDX_W'(j)]      = 1'b1;
        grant_idx             = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/tpu_job_scheduler.sv
// Round-robin job scheduler for a shared TPU datapath with watchdog abort
// and per-requester completion reporting.
module tpu_job_scheduler
  import tpu_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TAG_WIDTH      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned ABORT_CYCLES   = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*TAG_WIDTH-1:0]   req_tag,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           tpu_start,
  input  logic                           tpu_done,
  output logic                           tpu_abort,
  output logic [NUM_REQ-1:0]             cmp_valid,
  output logic [TAG_WIDTH-1:0]           cmp_tag,
  output logic                           cmp_timeout,
  output logic                           busy,
  output logic                           spurious_done,
  output logic [15:0]                    job_count
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned WD_W  = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned AB_W  = $clog2(ABORT_CYCLES + 1);

  state_e               state, state_nxt;
  logic [IDX_W-1:0]     rr_ptr, win_q, grant_idx;
  logic [NUM_REQ-1:0]   grant;
  logic [TAG_WIDTH-1:0] tag_q, tag_sel;
  logic                 status_q;
  logic [WD_W-1:0]      wd;
  logic [AB_W-1:0]      ab_cnt;
  logic                 wd_expired, ab_last;

  tpu_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req       (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign wd_expired = (wd == WD_W'(TIMEOUT_CYCLES - 1));
  assign ab_last    = (ab_cnt == AB_W'(ABORT_CYCLES - 1));

  // Tag of the current arbitration winner
  always_comb begin
    tag_sel = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == IDX_W'(i)) tag_sel = req_tag[i*TAG_WIDTH +: TAG_WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (|req_valid) state_nxt = ST_START;
      ST_START:    state_nxt = ST_RUN;
      ST_RUN: begin
        // done wins over a coincident timeout
        if (tpu_done)        state_nxt = ST_COMPLETE;
        else if (wd_expired) state_nxt = ST_ABORT;
      end
      ST_ABORT:    if (ab_last) state_nxt = ST_COMPLETE;
      ST_COMPLETE: state_nxt = tpu_done ? ST_DRAIN : ST_IDLE;
      ST_DRAIN:    if (!tpu_done) state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; req_ready is the only input-dependent one
  always_comb begin
    req_ready   = '0;
    tpu_start   = 1'b0;
    tpu_abort   = 1'b0;
    cmp_valid   = '0;
    cmp_tag     = '0;
    cmp_timeout = 1'b0;
    busy        = 1'b1;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (!rst) req_ready = grant;
      end
      ST_START: tpu_start = 1'b1;
      ST_ABORT: tpu_abort = 1'b1;
      ST_COMPLETE: begin
        cmp_valid   = NUM_REQ'(1) << win_q;
        cmp_tag     = tag_q;
        cmp_timeout = status_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr        <= '0;
      win_q         <= '0;
      tag_q         <= '0;
      status_q      <= STATUS_OK;
      wd            <= '0;
      ab_cnt        <= '0;
      job_count     <= '0;
      spurious_done <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|req_valid) begin
            win_q <= grant_idx;
            tag_q <= tag_sel;
          end
        end
        ST_START: wd <= '0;
        ST_RUN: begin
          wd       <= wd + WD_W'(1);
          ab_cnt   <= '0;
          status_q <= tpu_done ? STATUS_OK : STATUS_TIMEOUT;
        end
        ST_ABORT: ab_cnt <= ab_cnt + AB_W'(1);
        ST_COMPLETE: begin
          rr_ptr    <= (win_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_q + IDX_W'(1);
          job_count <= job_count + 16'd1;
        end
        default: ;
      endcase
      if ((state == ST_IDLE || state == ST_START) && tpu_done) spurious_done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tpu_job_scheduler.sv
// Randomized bench for tpu_job_scheduler against a transaction-level model.
module tb_tpu_job_scheduler;

  localparam int NUM_REQ        = 4;
  localparam int TAG_WIDTH      = 4;
  localparam int TIMEOUT_CYCLES = 8;
  localparam int ABORT_CYCLES   = 2;

  logic                         clk = 1'b0;
  logic                         rst = 1'b1;
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ*TAG_WIDTH-1:0] req_tag;
  logic [NUM_REQ-1:0]           req_ready;
  logic                         tpu_start;
  logic                         tpu_done = 1'b0;
  logic                         tpu_abort;
  logic [NUM_REQ-1:0]           cmp_valid;
  logic [TAG_WIDTH-1:0]         cmp_tag;
  logic                         cmp_timeout;
  logic                         busy;
  logic                         spurious_done;
  logic [15:0]                  job_count;

  logic [NUM_REQ-1:0]   pend_valid = '0;
  logic [TAG_WIDTH-1:0] pend_tag [NUM_REQ];

  int n_checks = 0;
  int n_fail   = 0;
  int ptr_m    = 0;
  int exp_jobs = 0;
  int refill_mode = 0;

  tpu_job_scheduler #(
    .NUM_REQ(NUM_REQ), .TAG_WIDTH(TAG_WIDTH),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .ABORT_CYCLES(ABORT_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_tag(req_tag),
    .req_ready(req_ready), .tpu_start(tpu_start), .tpu_done(tpu_done),
    .tpu_abort(tpu_abort), .cmp_valid(cmp_valid), .cmp_tag(cmp_tag),
    .cmp_timeout(cmp_timeout), .busy(busy), .spurious_done(spurious_done),
    .job_count(job_count)
  );

  always #5 clk = ~clk;

  assign req_valid = pend_valid;
  always_comb begin
    req_tag = '0;
    for (int i = 0; i < NUM_REQ; i++) req_tag[i*TAG_WIDTH +: TAG_WIDTH] = pend_tag[i];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  // Winner = first pending requester at or after the pointer, wrapping
  function automatic int model_winner();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pend_valid[(ptr_m + i) % NUM_REQ]) return (ptr_m + i) % NUM_REQ;
    end
    return -1;
  endfunction

  task automatic refill();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (refill_mode == 2 || (refill_mode == 1 && !pend_valid[i] && $urandom_range(0, 1) == 1)) begin
        pend_valid[i] = 1'b1;
        pend_tag[i]   = TAG_WIDTH'($urandom);
      end
    end
  endtask

  // Runs one job starting from a negedge in IDLE; done raised in RUN cycle k
  // (k >= TIMEOUT_CYCLES means never) and held for h further cycles.
  task automatic do_job(input int k, input int h, output int w);
    logic [TAG_WIDTH-1:0] etag;
    logic                 eto;
    if (pend_valid == '0) begin
      int r;
      r = $urandom_range(0, NUM_REQ - 1);
      pend_valid[r] = 1'b1;
      pend_tag[r]   = TAG_WIDTH'($urandom);
    end
    check("idle_busy", 32'(busy), 32'd0);
    #1;
    w = model_winner();
    check("ready", 32'(req_ready), 32'd1 << w);
    etag = pend_tag[w];
    @(negedge clk);
    check("start", 32'({tpu_start, busy}), 32'd3);
    check("ready_after_accept", 32'(req_ready), 32'd0);
    pend_valid[w] = 1'b0;
    refill();
    eto = 1'b1;
    for (int r = 0; r < TIMEOUT_CYCLES; r++) begin
      @(negedge clk);
      check("run_quiet", 32'({tpu_start, tpu_abort, cmp_valid}), 32'd0);
      if (r == k) begin
        tpu_done = 1'b1;
        eto      = 1'b0;
        break;
      end
    end
    if (eto) begin
      for (int a = 0; a < ABORT_CYCLES; a++) begin
        @(negedge clk);
        check("abort", 32'({tpu_abort, cmp_valid}), 32'h10);
      end
    end
    @(negedge clk);
    check("cmp_valid", 32'(cmp_valid), 32'd1 << w);
    check("cmp_tag", 32'(cmp_tag), 32'(etag));
    check("cmp_timeout", 32'(cmp_timeout), 32'(eto));
    check("cmp_abort_low", 32'(tpu_abort), 32'd0);
    ptr_m = (w + 1) % NUM_REQ;
    exp_jobs++;
    if (eto || h == 0) tpu_done = 1'b0;
    if (!eto) begin
      for (int d = 1; d <= h; d++) begin
        @(negedge clk);
        check("drain", 32'({busy, req_ready, cmp_valid}), 32'h100);
        if (d == h) tpu_done = 1'b0;
      end
    end
    @(negedge clk);
    check("job_count", 32'(job_count), 32'(exp_jobs & 16'hFFFF));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int w;
    int start;
    for (int i = 0; i < NUM_REQ; i++) pend_tag[i] = '0;
    repeat (3) @(negedge clk);
    check("rst_outputs", 32'({req_ready, tpu_start, tpu_abort, cmp_valid, cmp_tag,
                              cmp_timeout, busy, spurious_done}), 32'd0);
    check("rst_job_count", 32'(job_count), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // single job from requester 2, tag 5
    pend_valid[2] = 1'b1;
    pend_tag[2]   = 4'h5;
    do_job(5, 0, w);
    check("single_winner", 32'(w), 32'd2);

    // fairness: every requester always pending
    refill_mode = 2;
    refill();
    start = ptr_m;
    for (int i = 0; i < 8; i++) begin
      do_job($urandom_range(0, TIMEOUT_CYCLES - 2), 0, w);
      check("fair_order", 32'(w), 32'((start + i) % NUM_REQ));
    end

    do_job(TIMEOUT_CYCLES, 0, w);        // pure timeout
    do_job(TIMEOUT_CYCLES - 1, 0, w);    // done on the timeout cycle
    do_job(3, 5, w);                     // sticky done with others pending

    refill_mode = 1;
    for (int i = 0; i < 40; i++)
      do_job($urandom_range(0, TIMEOUT_CYCLES + 1), $urandom_range(0, 3), w);

    refill_mode = 0;
    for (int i = 0; i < NUM_REQ && pend_valid != '0; i++)
      do_job($urandom_range(0, 3), 0, w);

    // spurious done in IDLE
    check("spurious_clear", 32'(spurious_done), 32'd0);
    tpu_done = 1'b1;
    @(negedge clk);
    tpu_done = 1'b0;
    check("spurious_set", 32'(spurious_done), 32'd1);
    check("spurious_quiet", 32'({busy, cmp_valid}), 32'd0);
    @(negedge clk);

    // reset mid-RUN with a non-zero pointer
    pend_valid[2] = 1'b1;
    pend_tag[2]   = 4'hA;
    do_job(1, 0, w);
    pend_valid[2] = 1'b1;
    #1;
    check("pre_rst_ready", 32'(req_ready), 32'd4);
    @(negedge clk);
    pend_valid    = 4'b1010;
    pend_tag[1]   = 4'h3;
    pend_tag[3]   = 4'hC;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrun_rst_outputs", 32'({req_ready, tpu_start, tpu_abort, cmp_valid, cmp_tag,
                                     cmp_timeout, busy, spurious_done}), 32'd0);
    check("midrun_rst_count", 32'(job_count), 32'd0);
    @(negedge clk);
    rst      = 1'b0;
    ptr_m    = 0;
    exp_jobs = 0;
    do_job(2, 0, w);
    check("ptr_after_rst", 32'(w), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
